// File: rtl/output_accum_writeback.sv
// Read-modify-write accumulator in front of the output SRAM: sums partial Winograd
// tiles across channel passes, applies ReLU on the last pass, writes one word per tile.
module output_accum_writeback #(
  parameter int LANES  = 32,
  parameter int LANE_W = 16,
  parameter int DATA_W = 512,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tile_valid,
  output logic              tile_ready,
  input  logic [ADDR_W-1:0] tile_addr,
  input  logic [DATA_W-1:0] tile_data,
  input  logic              tile_first,
  input  logic              tile_last,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [15:0]       tiles_written,
  output logic              addr_err
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [LANE_W:0]   s;
    logic [DATA_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      // one extra sign bit per lane; disagreement between the top two bits means overflow
      s = {a[i*LANE_W+LANE_W-1], a[i*LANE_W +: LANE_W]} +
          {b[i*LANE_W+LANE_W-1], b[i*LANE_W +: LANE_W]};
      if (s[LANE_W] != s[LANE_W-1])
        r[i*LANE_W +: LANE_W] = {s[LANE_W], {(LANE_W-1){~s[LANE_W]}}};
      else
        r[i*LANE_W +: LANE_W] = s[LANE_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = a;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (a[i*LANE_W+LANE_W-1]) r[i*LANE_W +: LANE_W] = '0;
    end
    return r;
  endfunction

  state_t              state, state_n;
  logic [ADDR_W-1:0]   cap_addr, addr_n;
  logic [DATA_W-1:0]   cap_data, data_n;
  logic                cap_last, last_n;
  logic                ready_n, rd_en_n, wr_en_n, err_n;
  logic [ADDR_W-1:0]   rd_addr_n, wr_addr_n;
  logic [DATA_W-1:0]   wr_data_n, acc;
  logic [15:0]         count_n;

  assign acc = sat_add(mem_rd_data, cap_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cap_addr      <= '0;
      cap_data      <= '0;
      cap_last      <= 1'b0;
      tile_ready    <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_rd_addr   <= '0;
      mem_wr_en     <= 1'b0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      tiles_written <= '0;
      addr_err      <= 1'b0;
    end else begin
      state         <= state_n;
      cap_addr      <= addr_n;
      cap_data      <= data_n;
      cap_last      <= last_n;
      tile_ready    <= ready_n;
      mem_rd_en     <= rd_en_n;
      mem_rd_addr   <= rd_addr_n;
      mem_wr_en     <= wr_en_n;
      mem_wr_addr   <= wr_addr_n;
      mem_wr_data   <= wr_data_n;
      tiles_written <= count_n;
      addr_err      <= err_n;
    end
  end

  // Outputs are registered, so this block computes their values for the next state.
  always_comb begin
    state_n   = state;
    addr_n    = cap_addr;
    data_n    = cap_data;
    last_n    = cap_last;
    rd_en_n   = 1'b0;
    rd_addr_n = mem_rd_addr;
    wr_en_n   = 1'b0;
    wr_addr_n = mem_wr_addr;
    wr_data_n = mem_wr_data;
    count_n   = tiles_written;
    err_n     = addr_err;
    case (state)
      IDLE: begin
        if (tile_valid && tile_ready) begin
          if ({1'b0, tile_addr} >= DEPTH_LIM) begin
            err_n = 1'b1;
          end else begin
            addr_n = tile_addr;
            data_n = tile_data;
            last_n = tile_last;
            if (tile_first) begin
              wr_en_n   = 1'b1;
              wr_addr_n = tile_addr;
              wr_data_n = tile_last ? relu(tile_data) : tile_data;
              state_n   = WRITE;
            end else begin
              rd_en_n   = 1'b1;
              rd_addr_n = tile_addr;
              state_n   = READ;
            end
          end
        end
      end
      READ: state_n = WAIT;
      WAIT: begin
        wr_en_n   = 1'b1;
        wr_addr_n = cap_addr;
        wr_data_n = cap_last ? relu(acc) : acc;
        state_n   = WRITE;
      end
      WRITE: begin
        count_n = tiles_written + 16'd1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
  end

endmodule

// File: tb/tb_output_accum_writeback.sv
// Directed bench for output_accum_writeback: lanewise reference model, a behavioural
// SRAM, and a per-cycle compare process for strobes, addresses, data and timing.
module tb_output_accum_writeback;
  localparam int LANES  = 32;
  localparam int LANE_W = 16;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              tile_valid = 1'b0;
  logic              tile_ready;
  logic [ADDR_W-1:0] tile_addr = '0;
  logic [DATA_W-1:0] tile_data = '0;
  logic              tile_first = 1'b0;
  logic              tile_last = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [15:0]       tiles_written;
  logic              addr_err;

  always #5 clk = ~clk;

  output_accum_writeback #(
    .LANES(LANES), .LANE_W(LANE_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_addr(tile_addr),
    .tile_data(tile_data), .tile_first(tile_first), .tile_last(tile_last),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .tiles_written(tiles_written), .addr_err(addr_err)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic [DATA_W-1:0] mem     [0:255];
  logic [DATA_W-1:0] ref_mem [0:255];
  exp_t wr_q[$];
  exp_t rd_q[$];
  exp_t ce;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  logic exp_err = 1'b0;
  int   ready_at = 0;
  logic in_rst = 1'b1;

  // SRAM with one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic logic [DATA_W-1:0] fill(input int v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = 16'(v);
    return r;
  endfunction

  function automatic logic [15:0] lane(input logic [DATA_W-1:0] w, input int i);
    return w[i*LANE_W +: LANE_W];
  endfunction

  function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] old, input logic [DATA_W-1:0] inc,
                                              input logic first, input logic last);
    logic [DATA_W-1:0] r;
    int a, b, v;
    for (int i = 0; i < LANES; i++) begin
      a = $signed(old[i*LANE_W +: LANE_W]);
      b = $signed(inc[i*LANE_W +: LANE_W]);
      v = first ? b : a + b;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      if (last && v < 0) v = 0;
      r[i*LANE_W +: LANE_W] = 16'(v);
    end
    return r;
  endfunction

  // Present a tile (held across busy cycles) until the handshake, then post expectations.
  task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic f, input logic l);
    int   t;
    logic r;
    logic ok;
    exp_t e;
    ok = 1'b0;
    t = 0;
    tile_valid = 1'b1; tile_addr = a; tile_data = d; tile_first = f; tile_last = l;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      r = tile_ready;
      t = cyc;
      @(posedge clk);
      #1;
      if (r) begin ok = 1'b1; break; end
    end
    tile_valid = 1'b0;
    if (!ok) begin
      fail("handshake_timeout");
      return;
    end
    if (int'(a) >= DEPTH) begin
      exp_err  = 1'b1;
      ready_at = t + 1;
    end else begin
      e.addr = a;
      e.data = model(ref_mem[a], d, f, l);
      ref_mem[a] = e.data;
      if (f) begin
        e.cyc    = t + 1;
        ready_at = t + 2;
      end else begin
        e.cyc = t + 1;
        rd_q.push_back(e);
        e.cyc    = t + 3;
        ready_at = t + 4;
      end
      wr_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (wr_q.size() == 0 && rd_q.size() == 0 && tile_ready) begin done = 1'b1; break; end
    end
    if (!done) fail("drain_timeout");
  endtask

  always @(negedge clk) begin
    if (!in_rst) begin
      chk("tile_ready", DATA_W'(tile_ready), DATA_W'(cyc >= ready_at));
      chk("rd_wr_exclusive", DATA_W'(mem_rd_en && mem_wr_en), '0);
      chk("tiles_written", DATA_W'(tiles_written), DATA_W'(exp_cnt[15:0]));
      chk("addr_err", DATA_W'(addr_err), DATA_W'(exp_err));
      if (mem_rd_en) begin
        if (rd_q.size() == 0) fail("unexpected_read");
        else begin
          ce = rd_q.pop_front();
          chk("rd_addr", DATA_W'(mem_rd_addr), DATA_W'(ce.addr));
          chk("rd_cycle", DATA_W'(cyc), DATA_W'(ce.cyc));
        end
      end else if (rd_q.size() != 0 && cyc > rd_q[0].cyc) begin
        fail("missing_read");
        void'(rd_q.pop_front());
      end
      if (mem_wr_en) begin
        if (wr_q.size() == 0) fail("unexpected_write");
        else begin
          ce = wr_q.pop_front();
          chk("wr_addr", DATA_W'(mem_wr_addr), DATA_W'(ce.addr));
          chk("wr_data", mem_wr_data, ce.data);
          chk("wr_cycle", DATA_W'(cyc), DATA_W'(ce.cyc));
        end
        exp_cnt++;
      end else if (wr_q.size() != 0 && cyc > wr_q[0].cyc) begin
        fail("missing_write");
        void'(wr_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    fail("global_timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] saved;
    int cnt_before;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tile_ready", DATA_W'(tile_ready), '0);
    chk("rst_rd_en", DATA_W'(mem_rd_en), '0);
    chk("rst_wr_en", DATA_W'(mem_wr_en), '0);
    chk("rst_wr_data", mem_wr_data, '0);
    chk("rst_addrs", DATA_W'({mem_rd_addr, mem_wr_addr}), '0);
    chk("rst_count", DATA_W'(tiles_written), '0);
    chk("rst_err", DATA_W'(addr_err), '0);
    reset = 1'b1;
    in_rst = 1'b0;
    ready_at = cyc + 1;

    // first pass
    send(8'd5, fill(100), 1'b1, 1'b0);
    wait_done();
    chk("first_lane0", DATA_W'(lane(mem[5], 0)), DATA_W'(16'd100));
    chk("first_lane31", DATA_W'(lane(mem[5], 31)), DATA_W'(16'd100));
    chk("first_count", DATA_W'(tiles_written), DATA_W'(16'd1));

    // accumulate 100 + -30
    send(8'd5, fill(-30), 1'b0, 1'b0);
    wait_done();
    chk("acc_lane7", DATA_W'(lane(mem[5], 7)), DATA_W'(16'd70));
    chk("acc_count", DATA_W'(tiles_written), DATA_W'(16'd2));

    // saturation
    v = fill(10);
    v[15:0] = 16'd32000;
    v[31:16] = 16'hFFFF - 16'd31999;
    send(8'd5, v, 1'b1, 1'b0);
    v = fill(5);
    v[15:0] = 16'd1000;
    v[31:16] = 16'hFFFF - 16'd999;
    send(8'd5, v, 1'b0, 1'b0);
    wait_done();
    chk("sat_pos", DATA_W'(lane(mem[5], 0)), DATA_W'(16'h7FFF));
    chk("sat_neg", DATA_W'(lane(mem[5], 1)), DATA_W'(16'h8000));
    chk("sat_other", DATA_W'(lane(mem[5], 2)), DATA_W'(16'd15));

    // ReLU on last pass, and the same sum without it
    send(8'd9, fill(-5), 1'b1, 1'b0);
    send(8'd9, fill(2), 1'b0, 1'b1);
    send(8'd10, fill(-5), 1'b1, 1'b0);
    send(8'd10, fill(2), 1'b0, 1'b0);
    wait_done();
    chk("relu_zero", DATA_W'(lane(mem[9], 3)), '0);
    chk("norelu_neg3", DATA_W'(lane(mem[10], 3)), DATA_W'(16'hFFFD));
    for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = (i % 2 == 0) ? 16'hFFF9 : 16'd7;
    send(8'd11, v, 1'b1, 1'b1);
    wait_done();
    chk("first_last_relu", DATA_W'({lane(mem[11], 1), lane(mem[11], 0)}), DATA_W'(32'h0007_0000));

    // range errors, boundary 127/128
    cnt_before = int'(tiles_written);
    send(8'd200, fill(1), 1'b1, 1'b0);
    send(8'd128, fill(1), 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("err_set", DATA_W'(addr_err), DATA_W'(1'b1));
    chk("err_no_count", DATA_W'(tiles_written), DATA_W'(cnt_before));
    send(8'd127, fill(3), 1'b1, 1'b0);
    wait_done();
    chk("err_sticky", DATA_W'(addr_err), DATA_W'(1'b1));
    chk("legal_127", DATA_W'(lane(mem[127], 4)), DATA_W'(16'd3));

    // back-to-back same address
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < LANES; j++) v[j*LANE_W +: LANE_W] = 16'($urandom);
      send(8'd42, v, (i == 0), (i == 5));
    end
    wait_done();
    chk("b2b_final", mem[42], ref_mem[42]);

    // reset while waiting for read data
    saved = ref_mem[9];
    send(8'd9, fill(4), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_rst = 1'b1;
    #1;
    chk("abort_wr_en", DATA_W'(mem_wr_en), '0);
    chk("abort_rd_en", DATA_W'(mem_rd_en), '0);
    chk("abort_wr_data", mem_wr_data, '0);
    chk("abort_count", DATA_W'(tiles_written), '0);
    chk("abort_err", DATA_W'(addr_err), '0);
    chk("abort_ready", DATA_W'(tile_ready), '0);
    wr_q.delete();
    rd_q.delete();
    ref_mem[9] = saved;
    exp_cnt = 0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    in_rst = 1'b0;
    ready_at = cyc + 1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", DATA_W'(tile_ready), DATA_W'(1'b1));
    chk("post_rst_mem", mem[9], saved);
    send(8'd9, fill(1), 1'b0, 1'b0);
    wait_done();
    chk("post_rst_acc", DATA_W'(lane(mem[9], 0)), DATA_W'(16'd1));
    chk("post_rst_count", DATA_W'(tiles_written), DATA_W'(16'd1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_accum_writeback.md
Name: output_accum_writeback

Overview:
- Sits directly upstream of the output memory and is the only writer of its data port.
- Receives 512-bit Winograd output tiles from the PE array and accumulates partial sums across input-channel passes with a read-modify-write of the output SRAM entry.
- Applies optional ReLU on the final pass and writes the result back.
- Reports the number of tiles written and a sticky address-range error.

Parameters:
- LANES, 32, number of signed lanes per 512-bit word.
- LANE_W, 16, lane width in bits; LANES*LANE_W must equal DATA_W.
- DATA_W, 512, tile/word width.
- ADDR_W, 8, address width driven to the output memory.
- DEPTH, 128, number of valid output memory entries; addresses >= DEPTH are illegal.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tile_valid  input  1  PE tile available.
- tile_ready  output  1  block can accept a tile this cycle.
- tile_addr  input  ADDR_W  destination output-memory entry.
- tile_data  input  DATA_W  LANES packed signed partial sums; lane 0 = bits [LANE_W-1:0].
- tile_first  input  1  first channel pass: overwrite, no read.
- tile_last  input  1  final channel pass: apply ReLU before write.
- mem_rd_en  output  1  read request to output memory.
- mem_rd_addr  output  ADDR_W  read address.
- mem_rd_data  input  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- mem_wr_en  output  1  write strobe, one cycle per tile.
- mem_wr_addr  output  ADDR_W  write address.
- mem_wr_data  output  DATA_W  write data.
- tiles_written  output  16  count of completed writes, wraps 0xFFFF->0.
- addr_err  output  1  sticky; set when an out-of-range tile is dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; tile_ready=0 while reset is asserted.
  - mem_rd_en=0, mem_wr_en=0, all address/data outputs 0, tiles_written=0, addr_err=0.
  - Reset mid-operation aborts the tile; no partial write is issued.
- States: IDLE, READ, WAIT, WRITE. tile_ready=1 only in IDLE.
- IDLE: on tile_valid, capture addr/data/first/last and leave IDLE.
  - addr >= DEPTH: drop the tile, set addr_err, stay in IDLE, no memory access, no count.
  - first=1: go to WRITE with sum = tile_data.
  - first=0: go to READ.
- READ: mem_rd_en=1 and mem_rd_addr=captured addr for exactly one cycle; go to WAIT.
- WAIT: register sum = lanewise saturating add(mem_rd_data, captured data); go to WRITE.
- Saturating add: signed LANE_W per lane; result clamps to +32767 / -32768 at LANE_W=16. No carry crosses lanes.
- ReLU when last=1: lanes with a negative value become 0. Applied after the add, or to tile_data when first=1 and last=1.
- WRITE: for exactly one cycle, mem_wr_en=1, mem_wr_addr=captured addr, mem_wr_data=final value. tiles_written increments. Return to IDLE.
- Latency, tile accepted at cycle T:
  - first=1: write at T+1; next accept at T+2.
  - first=0: read at T+1, write at T+3; next accept at T+4.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- Outputs are registered. mem_wr_data/mem_wr_addr hold their last values when mem_wr_en=0.
- Back-to-back tiles to the same address are coherent: each write completes before the next tile is accepted.
- tile_valid while tile_ready=0 is ignored; upstream holds the tile until the handshake.
- addr_err clears only on reset.

Test Plan:
- First-pass write: tile_first=1, addr=5, all lanes=100 -> mem_wr_en one cycle after accept, addr 5, all lanes 100; no mem_rd_en; tiles_written=1.
- Accumulate: memory entry 5 holds 100s, tile_first=0, data lanes=-30 -> mem_rd_en at T+1, mem_wr_en at T+3 with lanes 70; tile_ready low T+1..T+3.
- Saturation: stored lane0=32000, lane1=-32000; incoming lane0=1000, lane1=-1000 -> written lane0=32767, lane1=-32768; other lanes unaffected.
- ReLU last pass: stored lanes=-5, incoming 2, tile_last=1 -> written lanes 0. Same incoming with last=0 -> lanes -3.
- Range error: tile_addr=200, DEPTH=128 -> no rd/wr strobes, addr_err=1 and stays 1 after a following legal tile; tiles_written unchanged.
- Reset abort: assert reset in WAIT -> outputs zero immediately, no write occurs; after release, tile_ready=1 and tiles_written=0.
